// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the PRBS-31 receive checker.
//
// Contents:
//   PRBS_LEN          length of the PRBS-31 history (31 bits)
//   TAP_A / TAP_B     history taps for x^31 + x^28 + 1 (bit 31 ago, bit 28 ago)
//   ERR_CNT_W         width of the saturating error counter
//   prbs_chk_state_t  checker state {SEARCH, LOCKED}
package prbs_pkg;

    localparam int PRBS_LEN  = 31;
    localparam int TAP_A     = 30;
    localparam int TAP_B     = 27;
    localparam int ERR_CNT_W = 16;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_chk_state_t;

endpackage

// File: rtl/deserializer_1toN_sr.sv
// deserializer_1toN_sr -- 1:WIDTH serial-to-parallel converter.
//
// A free-running bit counter (0..WIDTH-1) advances on every valid bit and
// frames words relative to the first valid bit after reset. The first bit of
// a word lands in word_out[WIDTH-1].
//
// Build option: PRBS_CHK_WORD_OUT_EN
//   defined   : shift register present, word_out/word_valid operate.
//   undefined : word_out = 0, word_valid = 0; only the bit counter and the
//               word_end strobe remain (the checker still needs boundaries).
//
// Ports:
//   clk, reset   bit clock, asynchronous active-high reset
//   data_in      serial bit
//   bit_valid    qualifies data_in; counter stalls when low
//   word_out     last completed word (registered)
//   word_valid   one-cycle pulse when word_out updates (registered)
//   word_end     combinational strobe: the current valid bit ends a word
module deserializer_1toN_sr
    import prbs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             word_end
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] bit_cnt;

    assign word_end = bit_valid && (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (bit_valid) begin
            bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
        end
    end

`ifdef PRBS_CHK_WORD_OUT_EN
    // Holds the first WIDTH-1 bits of the word in progress; the last bit is
    // taken straight from data_in when the word completes.
    logic [WIDTH-2:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_end;
            if (bit_valid) begin
                shreg <= {shreg[WIDTH-3:0], data_in};
            end
            if (word_end) begin
                word_out <= {shreg, data_in};
            end
        end
    end
`else
    // data_in only feeds the shift register, which this build omits.
    logic unused_data;
    assign unused_data = data_in;
    assign word_out    = '0;
    assign word_valid  = 1'b0;
`endif

endmodule

// File: rtl/prbs_checker_rx.sv
// prbs_checker_rx -- self-synchronizing PRBS-31 (x^31 + x^28 + 1) receive
// checker with lock acquisition, per-word loss detection, a saturating error
// counter and an optional 1:WIDTH deserializer.
//
// Build option: PRBS_CHK_WORD_OUT_EN (see deserializer_1toN_sr); when
// undefined word_out/word_valid are tied to 0 and the checker is unchanged.
//
// Ports:
//   clk         bit clock, one serial bit per cycle when bit_valid
//   reset       asynchronous active-high reset
//   data_in     serial PRBS bit (MSB-first)
//   bit_valid   qualifies data_in; when low only clr_err has an effect
//   clr_err     synchronous clear of err_cnt (wins over a same-cycle error)
//   locked      checker is in LOCKED
//   err_pulse   one-cycle pulse per mismatching bit while locked
//   err_cnt     saturating mismatch count (LOCKED only)
//   word_out    last completed word, first-received bit in WIDTH-1
//   word_valid  one-cycle pulse when word_out updates
module prbs_checker_rx
    import prbs_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LOCK_COUNT = 64,
    parameter int LOSS_ERRS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 bit_valid,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     word_out,
    output logic                 word_valid
);

    localparam int FILL_W  = $clog2(PRBS_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WERR_W  = $clog2(WIDTH + 1);

    prbs_chk_state_t     state;
    logic [PRBS_LEN-1:0] hist;
    logic [FILL_W-1:0]   fill;
    logic [MATCH_W-1:0]  match_cnt;
    logic [WERR_W-1:0]   word_err;
    logic [WERR_W-1:0]   word_err_nxt;
    logic                filled;
    logic                mismatch;
    logic                word_end;

    deserializer_1toN_sr #(
        .WIDTH(WIDTH)
    ) u_deser (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .bit_valid (bit_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_end  (word_end)
    );

    // Predictions are only meaningful once hist holds 31 received bits.
    assign filled       = (fill == FILL_W'(PRBS_LEN));
    assign mismatch     = bit_valid && filled && ((hist[TAP_A] ^ hist[TAP_B]) != data_in);
    // Error total of the current word including the bit being sampled now.
    assign word_err_nxt = word_err + WERR_W'(mismatch);
    assign locked       = (state == LOCKED);

    // NOTE: sequential state is updated with non-blocking assignments so that
    // every right-hand side sees the pre-edge value, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            // NOTE: hist is a plain shift register, not a memory array, so it
            // is cheap to reset and the fill counter never sees stale bits.
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            word_err  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                // Self-synchronous: history always tracks the line, errors included.
                hist <= {hist[PRBS_LEN-2:0], data_in};
                if (!filled) begin
                    fill <= fill + 1'b1;
                end
                if (state == SEARCH) begin
                    if (filled) begin
                        if (mismatch) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                            state     <= LOCKED;
                            match_cnt <= '0;
                            word_err  <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                end else begin
                    err_pulse <= mismatch;
                    if (word_end) begin
                        if (word_err_nxt >= WERR_W'(LOSS_ERRS)) begin
                            state     <= SEARCH;
                            fill      <= '0;
                            match_cnt <= '0;
                        end
                        word_err <= '0;
                    end else begin
                        word_err <= word_err_nxt;
                    end
                end
            end
        end
    end

    // Error counter is held across loss of lock; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (mismatch && (state == LOCKED) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prbs_checker_rx.sv
// tb_prbs_checker_rx -- self-checking bench for prbs_checker_rx with default
// parameters. A PRBS-31 source and a bit-level behavioural model (bit 31 ago
// XOR bit 28 ago, lock/loss rules, word framing) supply all expected values.
module tb_prbs_checker_rx;

    localparam int WIDTH      = 32;
    localparam int LOCK_COUNT = 64;
    localparam int LOSS_ERRS  = 8;
    localparam int LOCK_BITS  = LOCK_COUNT + 31;

`ifdef PRBS_CHK_WORD_OUT_EN
    localparam bit WORDS_ON = 1'b1;
`else
    localparam bit WORDS_ON = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             data_in   = 1'b0;
    logic             bit_valid = 1'b0;
    logic             clr_err   = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [15:0]      err_cnt;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;

    int errors = 0;
    int checks = 0;

    prbs_checker_rx #(
        .WIDTH     (WIDTH),
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_ERRS (LOSS_ERRS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .bit_valid (bit_valid),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .word_out  (word_out),
        .word_valid(word_valid)
    );

    always #5 clk = ~clk;

    // ---------------- PRBS-31 source ----------------
    bit tx_q[$];

    function automatic bit tx_next();
        bit b;
        b = tx_q[tx_q.size() - 31] ^ tx_q[tx_q.size() - 28];
        tx_q.push_back(b);
        void'(tx_q.pop_front());
        return b;
    endfunction

    // ---------------- Reference model ----------------
    bit             rx_q[$];
    bit             word_q[$];
    int             m_fill, m_run, m_word_err, m_bitpos;
    bit             m_locked, m_pulse, m_wvalid;
    bit [15:0]      m_err_cnt;
    bit [WIDTH-1:0] m_word;

    task automatic model_reset();
        rx_q.delete();
        word_q.delete();
        m_fill = 0; m_run = 0; m_word_err = 0; m_bitpos = 0;
        m_locked = 0; m_pulse = 0; m_wvalid = 0;
        m_err_cnt = '0; m_word = '0;
    endtask

    task automatic model_bit(input bit b);
        bit mism       = 1'b0;
        bit was_locked = m_locked;
        m_pulse  = 0;
        m_wvalid = 0;
        if (m_fill >= 31)
            mism = (rx_q[rx_q.size() - 31] ^ rx_q[rx_q.size() - 28]) != b;
        rx_q.push_back(b);
        if (rx_q.size() > 31) void'(rx_q.pop_front());
        if (!was_locked) begin
            if (m_fill >= 31) begin
                m_run = mism ? 0 : m_run + 1;
                if (m_run == LOCK_COUNT) begin
                    m_locked = 1; m_run = 0; m_word_err = 0;
                end
            end
        end else if (mism) begin
            m_pulse = 1;
            m_word_err++;
            if (m_err_cnt != 16'hFFFF) m_err_cnt++;
        end
        if (m_fill < 31) m_fill++;
        word_q.push_back(b);
        m_bitpos++;
        if (m_bitpos == WIDTH) begin
            m_bitpos = 0;
            for (int i = 0; i < WIDTH; i++) m_word[WIDTH-1-i] = word_q[i];
            word_q.delete();
            m_wvalid = 1;
            if (was_locked) begin
                if (m_word_err >= LOSS_ERRS) begin
                    m_locked = 0; m_fill = 0; m_run = 0;
                end
                m_word_err = 0;
            end
        end
    endtask

    function automatic logic [WIDTH+18:0] exp_vec();
        return {m_locked, m_pulse, m_err_cnt, WORDS_ON & m_wvalid, WORDS_ON ? m_word : {WIDTH{1'b0}}};
    endfunction

    // Drive one cycle at the falling edge, sample just after the rising edge.
    task automatic step(input bit b, input bit v, input bit clr);
        @(negedge clk);
        data_in   = b;
        bit_valid = v;
        clr_err   = clr;
        if (v) model_bit(b);
        else begin m_pulse = 0; m_wvalid = 0; end
        if (clr) m_err_cnt = '0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        bit_valid = 0; clr_err = 0; data_in = 0;
        #2 reset = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (err_cnt !== 16'd0)   begin errors++; $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); end
        checks++; if (err_pulse !== 1'b0)  begin errors++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        checks++; if (word_out !== '0)     begin errors++; $display("FAIL reset_word_out got=%h exp=0", word_out); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_clean_lock();
        for (int k = 1; k <= LOCK_BITS + 2 * WIDTH + 1; k++) begin
            step(tx_next(), 1, 0);
            checks++;
            if (locked !== (k >= LOCK_BITS)) begin
                errors++; $display("FAIL lock_time bit=%0d got=%b exp=%b", k, locked, k >= LOCK_BITS);
            end
            checks++;
            if (word_valid !== (WORDS_ON && (k % WIDTH == 0))) begin
                errors++; $display("FAIL word_cadence bit=%0d got=%b", k, word_valid);
            end
            checks++;
            if ({locked, err_pulse, err_cnt, word_valid, word_out} !== exp_vec()) begin
                errors++; $display("FAIL clean_model bit=%0d got=%h exp=%h",
                                   k, {locked, err_pulse, err_cnt, word_valid, word_out}, exp_vec());
            end
        end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err_cnt got=%h exp=0", err_cnt); end
    endtask

    task automatic test_single_flip();
        int pulses = 0;
        repeat (5) step(tx_next(), 1, 0);
        step(~tx_next(), 1, 0);
        pulses += int'(err_pulse);
        for (int k = 0; k < 40; k++) begin
            step(tx_next(), 1, 0);
            pulses += int'(err_pulse);
            checks++;
            if ({locked, err_pulse, err_cnt, word_valid, word_out} !== exp_vec()) begin
                errors++; $display("FAIL flip_model k=%0d got=%h exp=%h",
                                   k, {locked, err_pulse, err_cnt, word_valid, word_out}, exp_vec());
            end
        end
        checks++; if (pulses != 3)       begin errors++; $display("FAIL flip_pulses got=%0d exp=3", pulses); end
        checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL flip_err_cnt got=%0d exp=3", err_cnt); end
        checks++; if (locked !== 1'b1)   begin errors++; $display("FAIL flip_locked got=%b exp=1", locked); end
    endtask

    task automatic test_loss_relock();
        bit [15:0] held;
        while (m_bitpos != 0) step(tx_next(), 1, 0);
        for (int k = 0; k < WIDTH; k++) begin
            bit b = tx_next();
            if (k < 8) b = ~b;
            step(b, 1, 0);
            checks++;
            if (locked !== (k < WIDTH - 1)) begin
                errors++; $display("FAIL loss_time pos=%0d got=%b exp=%b", k, locked, k < WIDTH - 1);
            end
        end
        held = m_err_cnt;
        for (int k = 1; k <= LOCK_BITS; k++) begin
            step(tx_next(), 1, 0);
            checks++;
            if (locked !== (k >= LOCK_BITS)) begin
                errors++; $display("FAIL relock_time bit=%0d got=%b exp=%b", k, locked, k >= LOCK_BITS);
            end
            checks++;
            if ({locked, err_pulse, err_cnt, word_valid, word_out} !== exp_vec()) begin
                errors++; $display("FAIL relock_model bit=%0d got=%h exp=%h",
                                   k, {locked, err_pulse, err_cnt, word_valid, word_out}, exp_vec());
            end
        end
        checks++; if (err_cnt !== held) begin errors++; $display("FAIL relock_err_held got=%h exp=%h", err_cnt, held); end
    endtask

    task automatic test_saturation();
        step(1'b0, 0, 0);
        force dut.err_cnt = 16'hFFFE;
        #1 release dut.err_cnt;
        m_err_cnt = 16'hFFFE;
        step(~tx_next(), 1, 0);
        repeat (35) step(tx_next(), 1, 0);
        checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_err_cnt got=%h exp=ffff", err_cnt); end
        checks++; if (locked !== 1'b1)      begin errors++; $display("FAIL sat_locked got=%b exp=1", locked); end
        step(tx_next(), 1, 1);
        checks++; if (err_cnt !== 16'd0)    begin errors++; $display("FAIL clr_err_cnt got=%h exp=0", err_cnt); end
        // Clear coinciding with an error: the clear wins, later echoes count.
        step(~tx_next(), 1, 1);
        checks++; if (err_cnt !== 16'd0)    begin errors++; $display("FAIL clr_with_err got=%h exp=0", err_cnt); end
        step(tx_next(), 1, 0);
        repeat (35) step(tx_next(), 1, 0);
        checks++; if (err_cnt !== 16'd2)    begin errors++; $display("FAIL clr_echoes got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_gaps_reset();
        int vcount = 0;
        int cycles = 0;
        for (int k = 0; k < 400; k++) begin
            bit v = 1'($urandom_range(1, 0));
            step(v ? tx_next() : 1'($urandom_range(1, 0)), v, 0);
            checks++;
            if ({locked, err_pulse, err_cnt, word_valid, word_out} !== exp_vec()) begin
                errors++; $display("FAIL gap_model k=%0d got=%h exp=%h",
                                   k, {locked, err_pulse, err_cnt, word_valid, word_out}, exp_vec());
            end
        end
        while (m_bitpos == 0) step(tx_next(), 1, 0);
        // Asynchronous reset between clock edges, in the middle of a word.
        @(negedge clk);
        bit_valid = 0;
        #2 reset = 1;
        model_reset();
        #1;
        checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL areset_locked got=%b exp=0", locked); end
        checks++; if (err_cnt !== 16'd0)   begin errors++; $display("FAIL areset_err_cnt got=%h exp=0", err_cnt); end
        checks++; if (err_pulse !== 1'b0)  begin errors++; $display("FAIL areset_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL areset_word_valid got=%b exp=0", word_valid); end
        checks++; if (word_out !== '0)     begin errors++; $display("FAIL areset_word_out got=%h exp=0", word_out); end
        @(negedge clk);
        reset = 0;
        while (vcount < LOCK_BITS + 3 && cycles < 1000) begin
            bit v = 1'($urandom_range(1, 0));
            step(v ? tx_next() : 1'($urandom_range(1, 0)), v, 0);
            cycles++;
            if (v) vcount++;
            checks++;
            if (locked !== (vcount >= LOCK_BITS)) begin
                errors++; $display("FAIL gap_relock valid_bits=%0d got=%b exp=%b", vcount, locked, vcount >= LOCK_BITS);
            end
            checks++;
            if ({locked, err_pulse, err_cnt, word_valid, word_out} !== exp_vec()) begin
                errors++; $display("FAIL gap_relock_model valid_bits=%0d got=%h exp=%h",
                                   vcount, {locked, err_pulse, err_cnt, word_valid, word_out}, exp_vec());
            end
        end
        checks++;
        if (vcount < LOCK_BITS + 3) begin
            errors++; $display("FAIL gap_budget valid_bits=%0d required=%0d", vcount, LOCK_BITS + 3);
        end
    endtask

    initial begin
        for (int i = 0; i < 31; i++) tx_q.push_back(1'($urandom_range(1, 0)));
        tx_q[0] = 1'b1;
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_loss_relock();
        test_saturation();
        test_gaps_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/prbs_checker_rx.md
# prbs_checker_rx

Receive-side counterpart of the chip's PRBS serial transmit path. It samples the one-bit-per-clock serial stream and deserializes it into WIDTH-bit words. A self-synchronizing PRBS-31 checker (x^31 + x^28 + 1, MSB-first) acquires lock and counts bit errors for on-chip loopback and BER measurement. It sits on the same `clk` as the serializer, fed from a loopback or input pin.

## Interface
- WIDTH, 32: deserialized word width; must be ≥ 8.
- LOCK_COUNT, 64: consecutive correct predictions required to declare lock (≥ 1).
- LOSS_ERRS, 8: mismatches within one word that drop lock (1..WIDTH).
- clk  input  1  bit clock; one serial bit per cycle when `bit_valid`.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial PRBS bit.
- bit_valid  input  1  qualifies `data_in`; when low, no state changes except `clr_err`.
- clr_err  input  1  synchronous clear of `err_cnt`.
- locked  output  1  checker in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatching bit while locked.
- err_cnt  output  16  saturating mismatch count, LOCKED state only.
- word_out  output  WIDTH  last completed word; first-received bit in bit WIDTH-1.
- word_valid  output  1  one-cycle pulse when `word_out` updates.

## Operation
- Every valid bit shifts into a 31-bit history register `hist`, which is always loaded with received data (self-synchronous). Predicted bit = hist[30] ^ hist[27].
- fill counter: the first 31 valid bits after reset, or after any return to SEARCH, only fill `hist`. No predictions are made during fill.
- SEARCH:
  - A prediction match increments `match_cnt`. A mismatch clears it to 0.
  - Reaching LOCK_COUNT goes to LOCKED and clears `word_err`.
- LOCKED:
  - Each mismatch pulses `err_pulse`, increments `err_cnt` (saturates at 16'hFFFF) and increments `word_err`.
  - At each word boundary, `word_err` ≥ LOSS_ERRS → SEARCH. Otherwise `word_err` clears.
  - Entering SEARCH clears `match_cnt` and `fill`, and restarts the 31-bit fill. `err_cnt` is held.
- A single flipped line bit produces exactly 3 mismatches: the bit itself plus its two later tap uses.
- Deserializer:
  - A free-running bit counter 0..WIDTH-1 advances on valid bits.
  - Framing is relative to the first valid bit after reset; there is no word alignment search.
  - `word_out` and `word_valid` are produced independently of lock state.
- `clr_err` is synchronous. If asserted together with an error, `err_cnt` becomes 0.
- Reset value of all outputs and internal state is 0, with state = SEARCH.

## Timing
- All outputs are registered.
- `err_pulse` rises the cycle after the offending bit is sampled.
- `locked` rises the cycle after the LOCK_COUNT-th consecutive match is sampled. On a clean stream this is LOCK_COUNT+31 valid bits after reset.
- `locked` falls the cycle after the word boundary where the loss condition is met.
- `word_valid` pulses the cycle after the WIDTH-th bit of a word is sampled.
- A `bit_valid` gap stalls all counters and leaves no bubble in the bit order.
- Asynchronous reset mid-word discards the partial word, the fill and the lock, and returns to SEARCH.

## Configuration
- PRBS_CHK_WORD_OUT_EN:
  - Defined: deserializer present; `word_out` and `word_valid` operate as described.
  - Undefined: deserializer omitted; `word_out` = 0 and `word_valid` = 0 constantly; the checker is unaffected.
  - Word-boundary tracking for LOSS_ERRS is kept in both builds.

## Structure
- Shared package `prbs_pkg`:
  - PRBS-31 length (31) and tap indices (30, 27).
  - State typedef `prbs_chk_state_t` {SEARCH, LOCKED}.
  - Error counter width (16).
- Sub-module `deserializer_1toN_sr`: shift register plus bit counter, producing `word_out`, `word_valid` and a word-boundary strobe.
  - The strobe is kept even when PRBS_CHK_WORD_OUT_EN is undefined.

## Test plan
- Reset → `locked`=0, `err_cnt`=0, `err_pulse`=0, `word_valid`=0, `word_out`=0.
- Clean PRBS-31 stream, `bit_valid`=1, defaults → `locked` rises exactly 95 cycles after reset release. `err_cnt` stays 0. `word_valid` pulses every 32 cycles, with `word_out` matching the reference model.
- Flip one line bit while locked → exactly 3 `err_pulse` cycles, `err_cnt`=3, `locked` stays 1.
- Invert 8 consecutive bits within one word → `locked` drops at the end of that word. It relocks 95 valid bits later. `err_cnt` is held across the relock.
- Preload `err_cnt` to 16'hFFFE, then inject 3 errors → `err_cnt` saturates at 16'hFFFF. A `clr_err` pulse → 0.
- `bit_valid` toggled 50% pseudo-randomly, then reset asserted mid-word → lock and words match the gap-free model. After reset, all outputs are 0 and lock re-acquires after 95 valid bits.
